// File: rtl/ws_array_feeder.sv
// ws_array_feeder: buffers one ROWS-beat weight tile, bursts it gap-free into the weight chain, then streams skewed activations.
// Latency: activation accepted at t reaches column c at t+1+c with WS_FEEDER_SKEW_EN defined (t+1 for all columns otherwise).
// Backpressure: w_ready/a_ready are pure state decodes (COLLECT/STREAM); no combinational path from w_valid/a_valid.
module ws_array_feeder #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [COLS*WIDTH-1:0] w_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [COLS*WIDTH-1:0] a_data,
  input  logic                  a_last,
  output logic                  weight_wen,
  output logic [COLS*WIDTH-1:0] weight_din,
  output logic [COLS*WIDTH-1:0] a_out,
  output logic [COLS-1:0]       a_vld,
  output logic                  busy,
  output logic                  done
);

`ifdef WS_FEEDER_SKEW_EN
  localparam int SKEW_EN = 1;
`else
  localparam int SKEW_EN = 0;
`endif
  // DRAIN flushes the deepest skew column; without skew it is only the done cycle.
  localparam int DRAIN_LEN = SKEW_EN ? COLS - 1 : 0;
  localparam int CNT_MAX   = (ROWS > COLS) ? ROWS : COLS;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_BURST,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [COLS*WIDTH-1:0]   bank [ROWS];
  logic                    a_fire;
  logic [COLS*WIDTH-1:0]   inj_dat;

  // State and shared beat/burst/drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus state-decoded outputs; the whole tile is banked before BURST so wen never gaps.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_ready    = 1'b0;
    a_ready    = 1'b0;
    weight_wen = 1'b0;
    weight_din = '0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        w_ready = 1'b1;
        if (w_valid) begin
          if (cnt_q == CW'(ROWS - 1)) begin
            state_d = S_BURST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_BURST: begin
        weight_wen = 1'b1;
        weight_din = bank[cnt_q[RW-1:0]];
        if (cnt_q == CW'(ROWS - 1)) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STREAM: begin
        a_ready = 1'b1;
        if (a_valid && a_last) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(DRAIN_LEN)) begin
          done    = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Weight bank: host beat k lands in entry k; cleared on reset so a restarted tile never sees stale rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) bank[i] <= '0;
    end else if (state_q == S_COLLECT && w_valid) begin
      bank[cnt_q[RW-1:0]] <= w_data;
    end
  end

  // Idle slots inject zero operands so partial sums pass through unchanged.
  assign a_fire  = a_ready && a_valid;
  assign inj_dat = a_fire ? a_data : '0;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int DEPTH = SKEW_EN ? c + 1 : 1;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic             v_q [DEPTH];

    // Column c: common output register followed by c skew stages (one stage without skew).
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          d_q[i] <= '0;
          v_q[i] <= 1'b0;
        end
      end else begin
        d_q[0] <= inj_dat[c*WIDTH +: WIDTH];
        v_q[0] <= a_fire;
        for (int i = 1; i < DEPTH; i++) begin
          d_q[i] <= d_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign a_out[c*WIDTH +: WIDTH] = d_q[DEPTH-1];
    assign a_vld[c]                = v_q[DEPTH-1];
  end

endmodule

// File: tb/tb_ws_array_feeder.sv
// tb_ws_array_feeder: scoreboard bench for ws_array_feeder.
// Driver pushes expected weight bursts, per-column activation slots and done cycles;
// a negedge monitor pops and compares whenever the DUT presents weight_wen, a_vld or done.
module tb_ws_array_feeder;
  localparam int WIDTH = 8;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
`ifdef WS_FEEDER_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic                  w_valid = 1'b0;
  logic                  a_valid = 1'b0;
  logic                  a_last = 1'b0;
  logic [COLS*WIDTH-1:0] w_data = '0;
  logic [COLS*WIDTH-1:0] a_data = '0;
  logic                  w_ready, a_ready, weight_wen, busy, done;
  logic [COLS*WIDTH-1:0] weight_din, a_out;
  logic [COLS-1:0]       a_vld;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct packed {
    int               cyc;
    logic [WIDTH-1:0] dat;
  } a_exp_t;

  logic [COLS*WIDTH-1:0] w_exp_q [$];
  int                    burst_start_q [$];
  a_exp_t                col_q [COLS][$];
  int                    done_q [$];
  logic [COLS*WIDTH-1:0] tile_exp [ROWS];
  logic [COLS*WIDTH-1:0] pe_row [ROWS];
  logic [COLS*WIDTH-1:0] w_beats [ROWS];
  logic [COLS*WIDTH-1:0] a_beats [$];
  int                    run_len = 0;
  logic                  prev_done = 1'b0;

  ws_array_feeder #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_data     (a_data),
    .a_last     (a_last),
    .weight_wen (weight_wen),
    .weight_din (weight_din),
    .a_out      (a_out),
    .a_vld      (a_vld),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at cycle %0d (required finish)", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at cycle %0d: event occurred, required none", name, cyc);
  endtask

  // Monitor: pop expectations whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (rst) begin
      run_len   = 0;
      prev_done = 1'b0;
    end else begin
      if (weight_wen) begin
        if (run_len == 0) begin
          if (burst_start_q.size() == 0) fail("wen_unexpected");
          else check("burst_start_cyc", cyc, burst_start_q.pop_front());
        end
        if (w_exp_q.size() == 0) fail("weight_din_extra");
        else check("weight_din", weight_din, w_exp_q.pop_front());
        for (int r = ROWS - 1; r > 0; r--) pe_row[r] = pe_row[r-1];
        pe_row[0] = weight_din;
        run_len++;
      end else if (run_len != 0) begin
        check("burst_len", run_len, ROWS);
        for (int r = 0; r < ROWS; r++) check("pe_row", pe_row[r], tile_exp[r]);
        run_len = 0;
      end
      for (int c = 0; c < COLS; c++) begin
        if (a_vld[c]) begin
          if (col_q[c].size() == 0) fail("a_vld_extra");
          else begin
            a_exp_t e;
            e = col_q[c].pop_front();
            check("a_slot_cyc", cyc, e.cyc);
            check("a_out_dat", a_out[c*WIDTH +: WIDTH], e.dat);
          end
        end else begin
          check("a_out_idle_zero", a_out[c*WIDTH +: WIDTH], 0);
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail("done_extra");
        else check("done_cyc", cyc, done_q.pop_front());
        check("busy_during_done", busy, 1);
      end
      if (prev_done) check("busy_after_done", busy, 0);
      prev_done = done;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_w_ready"}, w_ready, 0);
    check({tag, "_a_ready"}, a_ready, 0);
    check({tag, "_weight_wen"}, weight_wen, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_weight_din"}, weight_din, 0);
    check({tag, "_a_out"}, a_out, 0);
    check({tag, "_a_vld"}, a_vld, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("w_ready_after_start", w_ready, 1);
    check("busy_after_start", busy, 1);
  endtask

  task automatic load_weights(input int wgap, output int t_last);
    int k = 0;
    int guard = 0;
    t_last = 0;
    for (int r = 0; r < ROWS; r++) tile_exp[r] = w_beats[ROWS-1-r];
    for (int i = 0; i < ROWS; i++) w_exp_q.push_back(w_beats[i]);
    while (k < ROWS) begin
      start   = 1'($urandom_range(1));
      w_valid = ($urandom_range(99) >= wgap);
      w_data  = w_valid ? w_beats[k] : $urandom;
      if (w_valid && w_ready) begin
        if (k == ROWS - 1) begin
          t_last = cyc;
          burst_start_q.push_back(cyc + 1);
        end
        k++;
      end
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        fail("weight_load_timeout");
        break;
      end
    end
    w_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic stream_tile(input int agap, input int gap_at, input int t_w);
    int i = 0;
    int hold = 0;
    int guard = 0;
    bit seen = 0;
    int n;
    a_exp_t e;
    n = a_beats.size();
    while (i < n) begin
      if (a_ready && !seen) begin
        seen = 1;
        check("stream_start_cyc", cyc, t_w + ROWS + 1);
      end
      start   = 1'($urandom_range(1));
      w_valid = 1'($urandom_range(1));
      w_data  = $urandom;
      if (a_ready && i == gap_at && hold < 2) begin
        a_valid = 1'b0;
        hold++;
      end else begin
        a_valid = ($urandom_range(99) >= agap);
      end
      a_data = a_valid ? a_beats[i] : $urandom;
      a_last = a_valid && (i == n - 1);
      if (a_valid && a_ready) begin
        for (int c = 0; c < COLS; c++) begin
          e.cyc = cyc + 1 + c * SKEW;
          e.dat = a_beats[i][c*WIDTH +: WIDTH];
          col_q[c].push_back(e);
        end
        if (a_last) done_q.push_back(cyc + (SKEW != 0 ? COLS : 1));
        i++;
      end
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        fail("stream_timeout");
        break;
      end
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
    start   = 1'b0;
    w_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy) begin
      @(negedge clk);
      guard++;
      if (guard > 60) begin
        fail("idle_timeout");
        break;
      end
    end
    check("done_q_drained", done_q.size(), 0);
    check("weight_q_drained", w_exp_q.size(), 0);
    for (int c = 0; c < COLS; c++) check("col_q_drained", col_q[c].size(), 0);
  endtask

  task automatic run_tile(input int wgap, input int agap, input int gap_at);
    int t;
    do_start();
    load_weights(wgap, t);
    stream_tile(agap, gap_at, t);
    wait_idle();
  endtask

  task automatic set_directed_weights();
    for (int k = 0; k < ROWS; k++)
      for (int c = 0; c < COLS; c++) w_beats[k][c*WIDTH +: WIDTH] = WIDTH'(16 * k + c);
  endtask

  task automatic set_random_acts(input int n);
    logic [COLS*WIDTH-1:0] b;
    a_beats.delete();
    for (int i = 0; i < n; i++) begin
      b = $urandom;
      a_beats.push_back(b);
    end
  endtask

  initial begin
    int a_dir [3][COLS];
    logic [COLS*WIDTH-1:0] b;
    int t;
    a_dir = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{-1, -2, -3, -4}};

    #1 rst = 1'b1;
    #1 check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed: back-to-back weights 16k+c, three-beat activation tile.
    set_directed_weights();
    a_beats.delete();
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < COLS; c++) b[c*WIDTH +: WIDTH] = WIDTH'(a_dir[i][c]);
      a_beats.push_back(b);
    end
    run_tile(0, 0, -1);

    // Same tile with gaps between weight beats.
    run_tile(60, 0, -1);

    // Two-cycle activation stall mid-tile.
    set_random_acts(4);
    run_tile(0, 0, 2);

    // Reset during the second BURST cycle, then a fresh tile.
    do_start();
    load_weights(0, t);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_outputs_zero("mid_reset");
    w_exp_q.delete();
    burst_start_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_directed_weights();
    set_random_acts(3);
    run_tile(0, 0, -1);

    // Randomized tiles.
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < ROWS; k++) w_beats[k] = $urandom;
      set_random_acts($urandom_range(1, 6));
      run_tile($urandom_range(60), $urandom_range(50), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ws_array_feeder.md
# ws_array_feeder

Top-edge driver for the weight-stationary systolic array of MAC PEs. It buffers one full weight tile from the host, then bursts it into the columns through the weight shift chain, asserting `weight_wen` on contiguous cycles. It then streams activation vectors into the columns with per-column skew and drains the skew pipeline. The array's bottom and right edges are read by the downstream result collector.

## Interface
- `WIDTH`, 8: weight and activation element width (signed).
- `ROWS`, 4: PE rows, which equals the weight beats per tile.
- `COLS`, 4: PE columns, which equals the elements per beat.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `w_valid`  in  1  weight beat valid.
- `w_ready`  out  1  weight beat accepted when `w_valid && w_ready`.
- `w_data`  in  COLS*WIDTH  one weight row vector; element c in bits [c*WIDTH +: WIDTH].
- `a_valid`  in  1  activation beat valid.
- `a_ready`  out  1  activation beat accepted when `a_valid && a_ready`.
- `a_data`  in  COLS*WIDTH  one activation vector; element c drives column c.
- `a_last`  in  1  marks the final activation beat of the tile.
- `weight_wen`  out  1  weight shift enable, broadcast to all PEs.
- `weight_din`  out  COLS*WIDTH  top-row weight input, per column.
- `a_out`  out  COLS*WIDTH  top-row activation input, per column.
- `a_vld`  out  COLS  per-column tag: `a_out` carries real data.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when the tile completes.

## Operation
- FSM states are IDLE, COLLECT, BURST, STREAM and DRAIN. Reset enters IDLE.
- IDLE: `start` moves to COLLECT.
- COLLECT:
  - `w_ready`=1.
  - Each accepted beat is written to weight bank entry k, where k is a counter from 0 to ROWS-1.
  - The ROWS-th accept moves to BURST; `w_ready` drops in that same cycle.
- BURST:
  - Lasts exactly ROWS consecutive cycles.
  - `weight_wen`=1 and `weight_din` = bank[k] for k=0..ROWS-1.
  - Host order is deepest row first: bank[0] lands in row ROWS-1 and bank[ROWS-1] lands in row 0.
  - The burst must never have a gap. Any `weight_wen`=0 cycle lets the PEs forward `a` down the column and corrupts the shift chain; this is the reason for the full-tile buffer.
  - `a_out`=0 and `a_vld`=0 throughout.
  - Then moves to STREAM.
- STREAM:
  - `a_ready`=1.
  - An accepted beat enters the skew stage with vld=1.
  - A cycle with no accept injects zeros with vld=0; zero operands leave the partial sums unchanged.
  - Accepting a beat with `a_last`=1 moves to DRAIN.
- DRAIN:
  - Injects COLS-1 zero/invalid slots so column COLS-1 emits its last element.
  - Then asserts `done` for one cycle and returns to IDLE.
  - DRAIN length is 0 when skew is compiled out, so `done` follows directly.
- Skew stage: column c is delayed by c cycles beyond a common output register. Implement as a triangular shift register of data plus vld.
- Arithmetic: none. Data is passed through bit-exact with no sign extension.
- Simultaneous events:
  - `start` outside IDLE is ignored.
  - `w_valid` outside COLLECT and `a_valid` outside STREAM are not accepted.
- Reset mid-operation: the state returns to IDLE, and bank contents and counters are cleared. The partial weights already in the array are not recovered; the host restarts the tile.

## Timing
- Reset values: `w_ready`, `a_ready`, `weight_wen`, `busy` and `done` are 0; `weight_din`, `a_out` and `a_vld` are all 0; the skew registers are 0.
- The `start` edge puts the FSM in COLLECT on the next cycle; `w_ready` is high from that cycle.
- Last weight accept at cycle t: BURST occupies t+1 .. t+ROWS, and STREAM (`a_ready`=1) begins at t+ROWS+1.
- Activation latency: a beat accepted at cycle t appears on column c at t+1+c.
- `a_last` accepted at t: `done`=1 at cycle t+COLS, or at t+1 when skew is compiled out. `busy` falls in the cycle after `done`.
- `w_ready` and `a_ready` are registered state decodes. They do not combinationally depend on `w_valid` or `a_valid`.

## Configuration
- `WS_FEEDER_SKEW_EN` defined:
  - Internal triangular skew as described above.
  - DRAIN lasts COLS-1 cycles.
- `WS_FEEDER_SKEW_EN` undefined:
  - All columns are registered once and emitted in the same cycle (latency 1).
  - DRAIN is skipped, and the array edge must be skewed externally.

## Test plan
- Weight load with back-to-back beats (ROWS=COLS=4), 4 beats whose element c of beat k is 16k+c → `weight_wen` high for exactly 4 consecutive cycles, starting one cycle after the 4th accept. `weight_din` sequence is beat0..beat3, and a PE-array model holds row 0 = beat3 and row 3 = beat0.
- Weight load with `w_valid` gaps (idle cycles between beats) → BURST is still 4 contiguous cycles with no `weight_wen` gap. Array weights are identical to the back-to-back case.
- Activation stream of 3 beats [1,2,3,4], [5,6,7,8], [-1,-2,-3,-4] (last) → column 2 shows 3, 7, -3 starting 3 cycles after the first accept with `a_vld[2]`=1. `done` pulses 4 cycles after the last accept.
- STREAM with `a_valid` dropping for 2 cycles mid-tile → 2 zero slots per column with `a_vld`=0. Column ordering and skew are preserved.
- Reset asserted during BURST cycle 2 → all outputs 0 asynchronously and FSM in IDLE. A fresh `start` and full tile then completes correctly.
- Compile without `WS_FEEDER_SKEW_EN`, 1 beat [9,9,9,9] with last → all columns show 9 on the cycle after the accept, and `done` is on that same cycle.
